// File: rtl/vga_overlay_pkg.sv
// Shared types and constants for the VGA overlay blocks.
// Colours are 24-bit RGB; coordinates are 11-bit pixel counters.
package vga_overlay_pkg;

   localparam int COORD_W  = 11;
   localparam int COLOUR_W = 24;

   typedef logic [COLOUR_W-1:0] colour_t;

   localparam colour_t DEF_COLOUR_BG   = 24'h777777;
   localparam colour_t DEF_COLOUR_ON   = 24'hFF0000;
   localparam colour_t DEF_COLOUR_OFF  = 24'h444444;
   localparam colour_t DEF_COLOUR_RISE = 24'hFFFF00;
   localparam colour_t DEF_COLOUR_FALL = 24'h0000FF;

   // Index width for n entries, never below one bit
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vga_led_grid_locator.sv
// Maps a pixel coordinate onto the LED grid (region, gap, row, column).
// Compare chains replace division so coordinates may jump freely.
module vga_led_grid_locator
   import vga_overlay_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 4,
   parameter int START_H  = 10,
   parameter int START_V  = 10,
   parameter int W        = 16,
   parameter int H        = 16,
   parameter int WG       = 4,
   parameter int HG       = 4
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [COORD_W-1:0]               vga_h,
   input  logic [COORD_W-1:0]               vga_v,
   output logic                             region_q,
   output logic                             gap_q,
   output logic [idx_w(NUM_REGS)-1:0]       row_q,
   output logic [idx_w(DATA_W)-1:0]         col_q
);

   localparam int RW    = idx_w(NUM_REGS);
   localparam int CW    = idx_w(DATA_W);
   localparam int PV    = H + HG;
   localparam int PH    = W + WG;
   localparam int TOT_W = WG + PH * DATA_W;
   localparam int TOT_H = NUM_REGS * PV - HG;

   int   rh, rv, row_i, col_i, rvo, rho;
   logic region_c, gap_c;

   // Locate the pixel: region test, then row/column by threshold chains
   always_comb begin
      rh       = int'(vga_h) - START_H;
      rv       = int'(vga_v) - START_V;
      region_c = (rh >= 0) && (rh < TOT_W) && (rv >= 0) && (rv < TOT_H);
      row_i    = 0;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (rv >= r * PV) row_i = r;
      end
      col_i = 0;
      for (int k = 1; k < DATA_W; k++) begin
         if (rh >= WG + k * PH) col_i = k;
      end
      rvo   = rv - row_i * PV;
      rho   = rh - WG - col_i * PH;
      gap_c = (rvo >= H) || (rh < WG) || (rho >= W);
   end

   // Pipeline stage 1: register the geometry decode
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         region_q <= 1'b0;
         gap_q    <= 1'b0;
         row_q    <= '0;
         col_q    <= '0;
      end else begin
         region_q <= region_c;
         gap_q    <= gap_c;
         row_q    <= RW'(row_i);
         col_q    <= CW'(col_i);
      end
   end

endmodule

// File: rtl/vga_display_register_bank.sv
// Shows NUM_REGS registers as rows of LEDs, sampled once per frame,
// with recently changed bits highlighted for HOLD_FRAMES frames.
module vga_display_register_bank
   import vga_overlay_pkg::*;
#(
   parameter int      DATA_W      = 8,
   parameter int      NUM_REGS    = 4,
   parameter int      START_H     = 10,
   parameter int      START_V     = 10,
   parameter int      W           = 16,
   parameter int      H           = 16,
   parameter int      WG          = 4,
   parameter int      HG          = 4,
   parameter int      HOLD_FRAMES = 30,
   parameter colour_t COLOUR_BG   = DEF_COLOUR_BG,
   parameter colour_t COLOUR_ON   = DEF_COLOUR_ON,
   parameter colour_t COLOUR_OFF  = DEF_COLOUR_OFF,
   parameter colour_t COLOUR_RISE = DEF_COLOUR_RISE,
   parameter colour_t COLOUR_FALL = DEF_COLOUR_FALL
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_REGS*DATA_W-1:0]   data_in,
   input  logic [COORD_W-1:0]           vga_h,
   input  logic [COORD_W-1:0]           vga_v,
   output logic [COLOUR_W-1:0]          pixel_out,
   output logic                         display_on
);

   localparam int RW = idx_w(NUM_REGS);
   localparam int CW = idx_w(DATA_W);
   localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

   typedef logic [DATA_W-1:0] word_t;

   word_t           snap [NUM_REGS];
   word_t           mask [NUM_REGS];
   word_t           chg  [NUM_REGS];
   logic [HW-1:0]   hold [NUM_REGS];
   logic            valid;
   logic            sample;

   logic            region_q, gap_q;
   logic [RW-1:0]   row_q;
   logic [CW-1:0]   col_q;

   logic [CW-1:0]   bidx;
   logic            bit_v, hl;
   colour_t         colour_c;

   assign sample = (vga_h == '0) && (vga_v == '0);

   vga_led_grid_locator #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .START_H  (START_H),
      .START_V  (START_V),
      .W        (W),
      .H        (H),
      .WG       (WG),
      .HG       (HG)
   ) u_locator (
      .clk      (clk),
      .reset_n  (reset_n),
      .vga_h    (vga_h),
      .vga_v    (vga_v),
      .region_q (region_q),
      .gap_q    (gap_q),
      .row_q    (row_q),
      .col_q    (col_q)
   );

   // Bits differing between the live input and the frame snapshot
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         chg[r] = data_in[r*DATA_W +: DATA_W] ^ snap[r];
      end
   end

   // Frame sample: update snapshot, accumulate changes, run hold timers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= 1'b0;
         for (int r = 0; r < NUM_REGS; r++) begin
            snap[r] <= '0;
            mask[r] <= '0;
            hold[r] <= '0;
         end
      end else if (sample) begin
         valid <= 1'b1;
         for (int r = 0; r < NUM_REGS; r++) begin
            snap[r] <= data_in[r*DATA_W +: DATA_W];
            if (valid) begin
               if (chg[r] != '0) begin
                  if (HOLD_FRAMES > 0) begin
                     mask[r] <= ((hold[r] != '0) ? mask[r] : '0) | chg[r];
                     hold[r] <= HW'(HOLD_FRAMES);
                  end
               end else if (hold[r] != '0) begin
                  hold[r] <= hold[r] - HW'(1);
                  if (hold[r] == HW'(1)) mask[r] <= '0;
               end
            end
         end
      end
   end

   // Colour of the located pixel from snapshot and highlight state
   always_comb begin
      bidx     = CW'(DATA_W - 1) - col_q;
      bit_v    = snap[row_q][bidx];
      hl       = mask[row_q][bidx] && (hold[row_q] != '0);
      colour_c = COLOUR_BG;
      if (region_q && !gap_q) begin
         if (hl) colour_c = bit_v ? COLOUR_RISE : COLOUR_FALL;
         else    colour_c = bit_v ? COLOUR_ON : COLOUR_OFF;
      end
   end

   // Pipeline stage 2: register colour and display enable
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pixel_out  <= '0;
         display_on <= 1'b0;
      end else begin
         pixel_out  <= colour_c;
         display_on <= region_q;
      end
   end

endmodule

// File: tb/tb_vga_display_register_bank.sv
// Bench for vga_display_register_bank: table vectors and sequences,
// expected pixels queued at drive time and compared two clocks later.
module tb_vga_display_register_bank;
   import vga_overlay_pkg::*;

   localparam logic [23:0] BG   = 24'h777777;
   localparam logic [23:0] ON   = 24'hFF0000;
   localparam logic [23:0] OFF  = 24'h444444;
   localparam logic [23:0] RISE = 24'hFFFF00;
   localparam logic [23:0] FALL = 24'h0000FF;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] data_in;
   logic [10:0] vga_h, vga_v;
   logic [23:0] pixel_out;
   logic        display_on;

   vga_display_register_bank dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .data_in    (data_in),
      .vga_h      (vga_h),
      .vga_v      (vga_v),
      .pixel_out  (pixel_out),
      .display_on (display_on)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [23:0] c;
      logic        d;
      string       n;
   } exp_t;

   typedef struct {
      int          h;
      int          v;
      logic [23:0] c;
      logic        d;
      string       n;
   } vec_t;

   exp_t q[$];
   exp_t e;
   vec_t vt[12];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   // Scoreboard: compare queued expectations when their cycle comes up
   always @(posedge clk) begin
      #1;
      cyc++;
      while (q.size() > 0 && q[0].due <= cyc) begin
         e = q.pop_front();
         checks++;
         if (pixel_out !== e.c || display_on !== e.d) begin
            failures++;
            $display("FAIL %s: got pixel=%h on=%b, want pixel=%h on=%b",
                     e.n, pixel_out, display_on, e.c, e.d);
         end
      end
   end

   task automatic drive(input int h, input int v);
      @(negedge clk);
      vga_h = 11'(h);
      vga_v = 11'(v);
   endtask

   task automatic px(input int h, input int v, input logic [23:0] c,
                     input logic d, input string n);
      exp_t x;
      drive(h, v);
      x.due = cyc + 2;
      x.c   = c;
      x.d   = d;
      x.n   = n;
      q.push_back(x);
   endtask

   task automatic sample(input logic [31:0] d);
      @(negedge clk);
      data_in = d;
      vga_h   = 11'd0;
      vga_v   = 11'd0;
      drive(500, 500);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      #2;
      if (q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations never came due", q.size());
         q.delete();
      end
   endtask

   function automatic int bh(input int k);
      return 14 + k * 20 + 5;
   endfunction

   function automatic int bv(input int r);
      return 10 + r * 20 + 5;
   endfunction

   task automatic row_chk(input int r, input logic [7:0] val,
                          input logic [7:0] hlm, input string n);
      logic [23:0] c;
      int          b;
      for (int k = 0; k < 8; k++) begin
         b = 7 - k;
         if (hlm[b]) c = val[b] ? RISE : FALL;
         else        c = val[b] ? ON : OFF;
         px(bh(k), bv(r), c, 1'b1, $sformatf("%s_r%0d_k%0d", n, r, k));
      end
      drain();
   endtask

   initial begin
      vt[0]  = '{14,  10, ON,  1'b1, "first_bit"};
      vt[1]  = '{13,  10, BG,  1'b1, "left_gap"};
      vt[2]  = '{174, 10, BG,  1'b0, "right_out"};
      vt[3]  = '{173, 10, BG,  1'b1, "right_gap"};
      vt[4]  = '{20,  26, BG,  1'b1, "row_gap"};
      vt[5]  = '{9,   10, BG,  1'b0, "left_out"};
      vt[6]  = '{14,  9,  BG,  1'b0, "top_out"};
      vt[7]  = '{14,  85, OFF, 1'b1, "bottom_bit"};
      vt[8]  = '{14,  86, BG,  1'b0, "bottom_out"};
      vt[9]  = '{29,  10, ON,  1'b1, "col0_last"};
      vt[10] = '{30,  10, BG,  1'b1, "col_gap"};
      vt[11] = '{157, 10, ON,  1'b1, "col7_bit"};

      reset_n = 1'b0;
      data_in = '0;
      vga_h   = 11'd500;
      vga_v   = 11'd500;
      #22;
      checks++;
      if (pixel_out !== 24'h0 || display_on !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: got pixel=%h on=%b, want 0 0",
                  pixel_out, display_on);
      end
      @(negedge clk);
      reset_n = 1'b1;

      // First sample: plain colours, no highlight
      sample(32'h0000_0081);
      row_chk(0, 8'h81, 8'h00, "first");

      // Exact two-clock latency across neighbouring pixels
      px(500, 500, BG, 1'b0, "lat_pre");
      px(14, 10, ON, 1'b1, "lat_hit");
      px(500, 500, BG, 1'b0, "lat_post");
      drain();

      // Geometry table
      for (int i = 0; i < 12; i++) begin
         px(vt[i].h, vt[i].v, vt[i].c, vt[i].d, vt[i].n);
      end
      drain();

      // Rise then fall on row 1
      sample(32'h0000_0F81);
      row_chk(1, 8'h0F, 8'h0F, "frameN");
      sample(32'h0000_F081);
      row_chk(1, 8'hF0, 8'hFF, "frameN1");
      row_chk(0, 8'h81, 8'h00, "row0_steady");
      repeat (29) sample(32'h0000_F081);
      px(bh(0), bv(1), RISE, 1'b1, "hold_last");
      drain();
      sample(32'h0000_F081);
      row_chk(1, 8'hF0, 8'h00, "hold_expired");

      // Change during hold: cumulative mask and reload
      sample(32'h0000_F181);
      repeat (5) sample(32'h0000_F181);
      sample(32'h0000_F381);
      row_chk(1, 8'hF3, 8'h03, "cumulative");
      repeat (29) sample(32'h0000_F381);
      px(bh(7), bv(1), RISE, 1'b1, "reload_b0");
      px(bh(6), bv(1), RISE, 1'b1, "reload_b1");
      drain();
      sample(32'h0000_F381);
      row_chk(1, 8'hF3, 8'h00, "reload_expired");

      // Mid-frame data change has no effect until next sample
      @(negedge clk);
      data_in = 32'h00AA_F381;
      px(50, 100, BG, 1'b0, "v100");
      drain();
      row_chk(2, 8'h00, 8'h00, "midframe");
      sample(32'h00AA_F381);
      row_chk(2, 8'hAA, 8'hAA, "after_sample");
      row_chk(1, 8'hF3, 8'h00, "row1_quiet");

      // Asynchronous reset mid-frame
      repeat (3) drive(14, 10);
      #2;
      checks++;
      if (display_on !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset: got on=%b, want 1", display_on);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (pixel_out !== 24'h0 || display_on !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: got pixel=%h on=%b, want 0 0",
                  pixel_out, display_on);
      end
      drive(500, 500);
      @(negedge clk);
      reset_n = 1'b1;
      sample(32'h0000_0F81);
      row_chk(1, 8'h0F, 8'h00, "post_reset");
      px(bh(0), bv(0), ON, 1'b1, "post_reset_r0");
      px(bh(0), bv(2), OFF, 1'b1, "post_reset_r2");
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
